systolic_seq_counter: RTL
=========================

SYSTOLIC_SEQ_COUNTER -- requirements
Module: systolic_seq_counter

Interface
REQ-001 Parameter WIDTH, 8, count register width in bits; legal range 2..16.
REQ-002 Parameter ARRAY_N, 4, systolic array dimension used for load-window decode; ARRAY_N SHALL be at most 2^WIDTH - 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 start  input  1  begin a count sequence; level-sampled.
REQ-006 enable  input  1  advance the count when high; freeze it when low.
REQ-007 clear  input  1  synchronous abort to IDLE; active-high.
REQ-008 mode  input  2  mode select: 0 = WRAP, 1 = SATURATE, 2 = ONESHOT, 3 = reserved (treated as ONESHOT).
REQ-009 term  input  WIDTH  terminal count value, inclusive.
REQ-010 count  output  WIDTH  current count value, registered.
REQ-011 busy  output  1  high while in RUN state, registered.
REQ-012 tc  output  1  terminal-count strobe, combinational.
REQ-013 done  output  1  one-cycle completion pulse, registered.
REQ-014 load_win  output  1  operand-load window flag, combinational.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-016 In IDLE, start=1 SHALL latch mode and term into internal registers, load count=0 and enter RUN on the next edge.
REQ-017 In RUN with enable=1 and count!=term_q, count SHALL increment by 1 per cycle.
REQ-018 In RUN with enable=0, count and state SHALL hold and tc SHALL stay 0.
REQ-019 tc SHALL equal (state==RUN) AND enable AND (count==term_q).
REQ-020 On tc in WRAP mode, count SHALL go to 0 and the FSM SHALL stay in RUN; done SHALL not pulse.
REQ-021 On tc in SATURATE mode, count SHALL hold term_q, the FSM SHALL enter HOLD, and done SHALL pulse high for exactly the next cycle.
REQ-022 On tc in ONESHOT mode, count SHALL hold term_q, the FSM SHALL enter IDLE, and done SHALL pulse high for exactly the next cycle.
REQ-023 In HOLD, count SHALL hold; start=1 SHALL restart exactly as from IDLE (REQ-016).
REQ-024 start SHALL be ignored in RUN; a mid-run change of mode or term SHALL have no effect until the next start.
REQ-025 clear=1 in any state SHALL force count=0 and state=IDLE on the next edge.
REQ-026 clear SHALL have priority over start and enable, and a cycle with clear=1 SHALL not produce a done pulse.
REQ-027 With term_q=0, tc SHALL assert on every enabled RUN cycle.
REQ-028 With term_q=2^WIDTH-1 in WRAP mode, count SHALL roll over to 0 with no out-of-range value.
REQ-029 busy SHALL be 1 exactly when state==RUN.
REQ-030 load_win SHALL equal busy AND (count < ARRAY_N).
REQ-031 Count arithmetic SHALL be unsigned modulo 2^WIDTH with no carry output.

Reset
REQ-032 When rst=0 at a clock edge, the block SHALL take state=IDLE, count=0, busy=0, done=0, mode_q=WRAP and term_q=0, overriding all other inputs.
REQ-033 With rst=0, tc and load_win SHALL evaluate to 0.
REQ-034 Reset asserted mid-sequence SHALL abort the sequence without a done pulse.
REQ-035 The block SHALL resume normal operation on the first edge after rst returns to 1.

Structure
REQ-036 State encodings (IDLE=0, RUN=1, HOLD=2) and mode constants SHALL reside in the shared package systolic_pkg.
REQ-037 The block SHALL be a single module with no sub-modules: one sequential process for state, count, latched mode/term and done, plus combinational decode for tc and load_win.

Verification
REQ-038 Reset check: hold rst=0 for 2 cycles with start=1 and enable=1 -> count=0, busy=0, done=0, tc=0 throughout.
REQ-039 ONESHOT sequence: mode=2, term=5, start for 1 cycle, enable=1 -> count steps 0..5, tc high at count=5, done pulses next cycle, busy falls, count holds 5.
REQ-040 WRAP sequence: mode=0, term=3, enable=1 for 10 cycles -> count 0,1,2,3,0,1,2,3,0,1; tc asserts each time count=3; done never asserts.
REQ-041 SATURATE with pause: mode=1, term=4, enable=0 for 2 cycles at count=2 -> count holds 2 with tc=0; count then reaches 4, FSM enters HOLD, done pulses once, and a later start restarts from 0.
REQ-042 clear priority: assert clear and start together at count=6 in RUN -> next cycle count=0, state=IDLE, no done pulse.
REQ-043 load_win and term changes: ARRAY_N=4, term=9 -> load_win high for count 0..3 only; changing term mid-run to 2 does not change the count sequence.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic sequence counter: FSM state encoding and
// the counting-mode constants latched at sequence start.
package systolic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Reserved mode 3 behaves as ONESHOT.
   typedef enum logic [1:0] {
      MODE_WRAP     = 2'd0,
      MODE_SATURATE = 2'd1,
      MODE_ONESHOT  = 2'd2,
      MODE_RESERVED = 2'd3
   } mode_t;

endpackage

// File: rtl/systolic_seq_counter_if.sv
// Control/status bundle between a sequencer (master) and the systolic counter
// (slave).
interface systolic_seq_counter_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic             enable;
   logic             clear;
   logic [1:0]       mode;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc;
   logic             done;
   logic             load_win;

   modport master (
      output start, enable, clear, mode, term,
      input  count, busy, tc, done, load_win
   );

   modport slave (
      input  start, enable, clear, mode, term,
      output count, busy, tc, done, load_win
   );

endinterface

// File: rtl/systolic_seq_counter.sv
// Sequence counter for a systolic array: counts 0..term with wrap, saturate or
// one-shot completion, and flags the first ARRAY_N counts as the operand-load window.
module systolic_seq_counter
   import systolic_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int ARRAY_N = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   systolic_seq_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] ARRAY_N_W = WIDTH'(ARRAY_N);
   localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

   state_t           r_state;
   mode_t            r_mode;
   logic [WIDTH-1:0] r_term;
   logic [WIDTH-1:0] r_count;
   logic             r_busy;
   logic             r_done;

   logic             w_at_term;
   logic             w_tc;
   logic             w_load_win;

   // Terminal-count and load-window decode; both are forced low while in reset.
   always_comb begin
      w_at_term  = (r_count == r_term);
      w_tc       = rst & (r_state == ST_RUN) & bus.enable & w_at_term;
      w_load_win = rst & r_busy & (r_count < ARRAY_N_W);
   end

   // Sequencer FSM with registered count, busy and done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_WRAP;
         r_term  <= ZERO_W;
         r_count <= ZERO_W;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (bus.clear) begin
         r_state <= ST_IDLE;
         r_count <= ZERO_W;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (bus.start) begin
                  r_mode  <= mode_t'(bus.mode);
                  r_term  <= bus.term;
                  r_count <= ZERO_W;
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_tc) begin
                  case (r_mode)
                     MODE_WRAP: begin
                        r_count <= ZERO_W;
                     end
                     MODE_SATURATE: begin
                        r_state <= ST_HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                     default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  endcase
               end else if (bus.enable) begin
                  r_count <= r_count + ONE_W;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= ZERO_W;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.count    = r_count;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.tc       = w_tc;
   assign bus.load_win = w_load_win;

endmodule
